// File: rtl/cond_seq_pkg.sv
// Shared definitions for the conductivity-probe excitation sequencer:
// register map, CTRL bits, FSM encoding, drive codes and reset defaults.
package cond_seq_pkg;

    localparam logic [4:0] ADDR_CTRL   = 5'h00;
    localparam logic [4:0] ADDR_PHASE  = 5'h04;
    localparam logic [4:0] ADDR_DEAD   = 5'h08;
    localparam logic [4:0] ADDR_NCYC   = 5'h0C;
    localparam logic [4:0] ADDR_STATUS = 5'h10;

    localparam int CTRL_START = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_ABORT = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FWD,
        ST_DEAD_A,
        ST_REV,
        ST_DEAD_B
    } state_t;

    localparam logic [1:0] DRV_OFF = 2'b00;
    localparam logic [1:0] DRV_FWD = 2'b01;
    localparam logic [1:0] DRV_REV = 2'b10;

    localparam int RST_PHASE_LEN = 100;
    localparam int RST_DEAD_LEN  = 10;
    localparam int RST_NUM_CYC   = 1;

endpackage

// File: rtl/cond_excitation_seq_phase_timer.sv
// Per-state up-counter: load clears the count and latches the length, so
// register writes made mid-phase only affect the next state entry.
module phase_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         ld_i,
    input  logic [W-1:0] len_i,
    output logic         expire_o,
    output logic         mid_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] len_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            len_q <= W'(1);
        end else if (ld_i) begin
            cnt_q <= '0;
            len_q <= len_i;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // len_q is never 0: phase lengths are clamped and dead states are skipped when 0
    assign expire_o = (cnt_q == len_q - 1'b1);
    assign mid_o    = (cnt_q == (len_q >> 1));
endmodule

// File: rtl/cond_excitation_seq.sv
// Bus-mapped probe excitation sequencer: forward / dead / reverse / dead
// drive with a mid-phase ADC strobe tagged by polarity.
module cond_excitation_seq
    import cond_seq_pkg::*;
#(
    parameter int PH_W = 16,
    parameter int DT_W = 8,
    parameter int NC_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  addr,
    input  logic        cs,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] d_in,
    output logic [31:0] d_out,
    output logic        mem_ready,
    output logic [1:0]  drive,
    output logic        sample_strb,
    output logic        sample_pol,
    output logic        busy
);
    state_t          state_q, state_d;
    logic [PH_W-1:0] phase_len_q;
    logic [DT_W-1:0] dead_len_q;
    logic [NC_W-1:0] num_cyc_q;
    logic [NC_W-1:0] cyc_done_q;
    logic            cont_q, done_q, pol_q;
    logic [1:0]      drive_q;

    logic            wr_ctrl, start, abort, last_cyc, eoc, ld, expire, mid;
    logic [PH_W-1:0] eff_ph, dead_ext, ld_len;
    logic [NC_W-1:0] eff_nc;
    logic            unused_rd;

    assign unused_rd = ^{rd, d_in};
    assign mem_ready = 1'b1;

    assign wr_ctrl  = cs & wr & (addr == ADDR_CTRL);
    assign abort    = wr_ctrl & d_in[CTRL_ABORT];
    assign start    = wr_ctrl & d_in[CTRL_START] & ~d_in[CTRL_ABORT] & (state_q == ST_IDLE);
    assign eff_ph   = (phase_len_q == '0) ? PH_W'(1) : phase_len_q;
    assign eff_nc   = (num_cyc_q == '0) ? NC_W'(1) : num_cyc_q;
    assign dead_ext = PH_W'(dead_len_q);
    assign last_cyc = ~cont_q & (({1'b0, cyc_done_q} + 1'b1) == {1'b0, eff_nc});

    phase_timer #(.W(PH_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .en_i     (state_q != ST_IDLE),
        .ld_i     (ld),
        .len_i    (ld_len),
        .expire_o (expire),
        .mid_o    (mid)
    );

    // Next-state decode; ld marks every state entry so the timer restarts.
    always_comb begin
        state_d = state_q;
        ld      = 1'b0;
        ld_len  = eff_ph;
        eoc     = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d = ST_FWD;
                ld      = 1'b1;
            end
            ST_FWD: if (expire) begin
                ld = 1'b1;
                if (dead_len_q != '0) begin
                    state_d = ST_DEAD_A;
                    ld_len  = dead_ext;
                end else begin
                    state_d = ST_REV;
                end
            end
            ST_DEAD_A: if (expire) begin
                state_d = ST_REV;
                ld      = 1'b1;
            end
            ST_REV: if (expire) begin
                if (dead_len_q != '0) begin
                    state_d = ST_DEAD_B;
                    ld      = 1'b1;
                    ld_len  = dead_ext;
                end else begin
                    eoc = 1'b1;
                end
            end
            ST_DEAD_B: if (expire) eoc = 1'b1;
            default: state_d = ST_IDLE;
        endcase
        if (eoc) begin
            if (last_cyc) begin
                state_d = ST_IDLE;
            end else begin
                state_d = ST_FWD;
                ld      = 1'b1;
            end
        end
        if (abort) begin
            state_d = ST_IDLE;
            ld      = 1'b0;
            eoc     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            phase_len_q <= PH_W'(RST_PHASE_LEN);
            dead_len_q  <= DT_W'(RST_DEAD_LEN);
            num_cyc_q   <= NC_W'(RST_NUM_CYC);
            cyc_done_q  <= '0;
            cont_q      <= 1'b0;
            done_q      <= 1'b0;
            pol_q       <= 1'b0;
            drive_q     <= DRV_OFF;
        end else begin
            state_q <= state_d;
            case (state_d)
                ST_FWD: begin
                    drive_q <= DRV_FWD;
                    pol_q   <= 1'b0;
                end
                ST_REV: begin
                    drive_q <= DRV_REV;
                    pol_q   <= 1'b1;
                end
                default: drive_q <= DRV_OFF;
            endcase

            if (cs && wr) begin
                case (addr)
                    ADDR_CTRL:   cont_q      <= d_in[CTRL_CONT];
                    ADDR_PHASE:  phase_len_q <= d_in[PH_W-1:0];
                    ADDR_DEAD:   dead_len_q  <= d_in[DT_W-1:0];
                    ADDR_NCYC:   num_cyc_q   <= d_in[NC_W-1:0];
                    ADDR_STATUS: done_q      <= 1'b0;
                    default: ;
                endcase
            end

            // Completion outranks a same-edge STATUS clear
            if (start) begin
                done_q     <= 1'b0;
                cyc_done_q <= '0;
            end else if (eoc) begin
                if (cyc_done_q != '1) cyc_done_q <= cyc_done_q + 1'b1;
                if (last_cyc) done_q <= 1'b1;
            end
        end
    end

    always_comb begin
        d_out = '0;
        case (addr)
            ADDR_CTRL:   d_out = {30'b0, cont_q, 1'b0};
            ADDR_PHASE:  d_out = 32'(phase_len_q);
            ADDR_DEAD:   d_out = 32'(dead_len_q);
            ADDR_NCYC:   d_out = 32'(num_cyc_q);
            ADDR_STATUS: d_out = {16'b0, 8'(cyc_done_q), 6'b0, done_q, state_q != ST_IDLE};
            default:     d_out = '0;
        endcase
    end

    assign drive       = drive_q;
    assign sample_pol  = pol_q;
    assign busy        = (state_q != ST_IDLE);
    assign sample_strb = ((state_q == ST_FWD) || (state_q == ST_REV)) && mid;
endmodule

// File: tb/tb_cond_excitation_seq.sv
// Self-checking bench: register tables, directed multi-cycle sequences and
// randomized runs compared against a per-cycle expected drive trace.
module tb_cond_excitation_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  addr = '0;
    logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [31:0] d_in = '0;
    logic [31:0] d_out;
    logic        mem_ready, sample_strb, sample_pol, busy;
    logic [1:0]  drive;

    int checks = 0;
    int errors = 0;

    cond_excitation_seq dut (
        .clk(clk), .rst(rst), .addr(addr), .cs(cs), .rd(rd), .wr(wr),
        .d_in(d_in), .d_out(d_out), .mem_ready(mem_ready), .drive(drive),
        .sample_strb(sample_strb), .sample_pol(sample_pol), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr_en;
        logic [4:0]  a;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [1:0] drv;
        logic       strb;
        logic       pol;
    } cyc_t;

    cyc_t exp_q[$];
    vec_t rst_tbl[7];
    vec_t wr_tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
        tick();
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic rd_reg(input logic [4:0] a, output logic [31:0] v);
        cs = 1'b1; rd = 1'b1; addr = a;
        #1;
        v = d_out;
        cs = 1'b0; rd = 1'b0;
    endtask

    // Expected-trace builders: one queue entry per clock of the sequence
    task automatic push_ph(input int len, input logic [1:0] d, input logic p);
        for (int k = 0; k < len; k++) exp_q.push_back('{d, (k == len / 2), p});
    endtask

    task automatic push_dead(input int n, input logic p);
        for (int k = 0; k < n; k++) exp_q.push_back('{2'b00, 1'b0, p});
    endtask

    task automatic build(input int ph, input int dl, input int nc);
        int p, n;
        p = (ph == 0) ? 1 : ph;
        n = (nc == 0) ? 1 : nc;
        exp_q.delete();
        for (int c = 0; c < n; c++) begin
            push_ph(p, 2'b01, 1'b0);
            push_dead(dl, 1'b0);
            push_ph(p, 2'b10, 1'b1);
            push_dead(dl, 1'b1);
        end
    endtask

    task automatic check_cycle(input int k);
        chk($sformatf("drive[%0d]", k), 32'(drive), 32'(exp_q[k].drv));
        chk($sformatf("strb[%0d]", k), 32'(sample_strb), 32'(exp_q[k].strb));
        chk($sformatf("pol[%0d]", k), 32'(sample_pol), 32'(exp_q[k].pol));
        chk($sformatf("busy[%0d]", k), 32'(busy), 32'd1);
    endtask

    task automatic run_from(input int k0);
        for (int k = k0; k < exp_q.size(); k++) begin
            tick();
            check_cycle(k);
        end
    endtask

    task automatic finish_check(input int n);
        logic [31:0] v;
        tick();
        chk("end_drive", 32'(drive), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);
        rd_reg(5'h10, v);
        chk("end_status", v, (32'(n) << 8) | 32'h2);
    endtask

    task automatic check_reset_regs();
        logic [31:0] v;
        foreach (rst_tbl[i]) begin
            rd_reg(rst_tbl[i].a, v);
            chk($sformatf("rst_reg_%0h", rst_tbl[i].a), v, rst_tbl[i].exp);
        end
        chk("rst_drive", 32'(drive), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_strb", 32'(sample_strb), 32'd0);
        chk("mem_ready", 32'(mem_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] v;
        int ph, dl, nc;

        rst_tbl[0] = '{1'b0, 5'h00, 32'h0, 32'd0};
        rst_tbl[1] = '{1'b0, 5'h04, 32'h0, 32'd100};
        rst_tbl[2] = '{1'b0, 5'h08, 32'h0, 32'd10};
        rst_tbl[3] = '{1'b0, 5'h0C, 32'h0, 32'd1};
        rst_tbl[4] = '{1'b0, 5'h10, 32'h0, 32'd0};
        rst_tbl[5] = '{1'b0, 5'h14, 32'h0, 32'd0};
        rst_tbl[6] = '{1'b0, 5'h1C, 32'h0, 32'd0};

        wr_tbl[0] = '{1'b1, 5'h04, 32'h1234ABCD, 32'h0000ABCD};
        wr_tbl[1] = '{1'b1, 5'h08, 32'h000001FF, 32'h000000FF};
        wr_tbl[2] = '{1'b1, 5'h0C, 32'h00000103, 32'h00000003};
        wr_tbl[3] = '{1'b1, 5'h00, 32'h00000002, 32'h00000002};
        wr_tbl[4] = '{1'b1, 5'h00, 32'h00000000, 32'h00000000};
        wr_tbl[5] = '{1'b1, 5'h14, 32'hFFFFFFFF, 32'h00000000};
        wr_tbl[6] = '{1'b1, 5'h10, 32'h0000FFFF, 32'h00000000};

        tick();
        tick();
        rst = 1'b0;
        check_reset_regs();

        foreach (wr_tbl[i]) begin
            if (wr_tbl[i].wr_en) wr_reg(wr_tbl[i].a, wr_tbl[i].wd);
            rd_reg(wr_tbl[i].a, v);
            chk($sformatf("wr_reg_%0d", i), v, wr_tbl[i].exp);
        end
        chk("tbl_busy", 32'(busy), 32'd0);

        // Two full cycles with dead time
        wr_reg(5'h04, 32'd4); wr_reg(5'h08, 32'd2); wr_reg(5'h0C, 32'd2);
        build(4, 2, 2);
        wr_reg(5'h00, 32'h1);
        check_cycle(0);
        run_from(1);
        finish_check(2);

        // No dead time, single-cycle phases
        wr_reg(5'h04, 32'd1); wr_reg(5'h08, 32'd0); wr_reg(5'h0C, 32'd3);
        build(1, 0, 3);
        wr_reg(5'h00, 32'h1);
        rd_reg(5'h10, v);
        chk("start_clears_done", v, 32'h1);
        check_cycle(0);
        run_from(1);
        finish_check(3);

        // Continuous mode, then abort during the second REV phase
        wr_reg(5'h04, 32'd4); wr_reg(5'h08, 32'd2); wr_reg(5'h0C, 32'd1);
        wr_reg(5'h00, 32'h3);
        repeat (19) tick();
        chk("cont_rev_drive", 32'(drive), 32'd2);
        rd_reg(5'h10, v);
        chk("cont_status", v, 32'h101);
        wr_reg(5'h00, 32'h4);
        chk("abort_drive", 32'(drive), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        rd_reg(5'h10, v);
        chk("abort_status", v, 32'h100);
        rd_reg(5'h00, v);
        chk("abort_ctrl", v, 32'h0);

        // START while busy is ignored; new PHASE_LEN applies from REV entry
        exp_q.delete();
        push_ph(4, 2'b01, 1'b0);
        push_dead(2, 1'b0);
        push_ph(2, 2'b10, 1'b1);
        push_dead(2, 1'b1);
        wr_reg(5'h00, 32'h1);
        check_cycle(0);
        wr_reg(5'h04, 32'd2);
        check_cycle(1);
        wr_reg(5'h00, 32'h1);
        check_cycle(2);
        run_from(3);
        finish_check(1);

        // Reset mid-sequence
        wr_reg(5'h04, 32'd7); wr_reg(5'h08, 32'd3); wr_reg(5'h0C, 32'd5);
        wr_reg(5'h00, 32'h3);
        tick();
        chk("pre_rst_drive", 32'(drive), 32'd1);
        rst = 1'b1;
        tick();
        chk("rst_mid_drive", 32'(drive), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        check_reset_regs();

        // Randomized runs against the trace model
        for (int it = 0; it < 6; it++) begin
            ph = $urandom_range(0, 5);
            dl = $urandom_range(0, 3);
            nc = $urandom_range(0, 3);
            wr_reg(5'h04, 32'(ph)); wr_reg(5'h08, 32'(dl)); wr_reg(5'h0C, 32'(nc));
            build(ph, dl, nc);
            wr_reg(5'h00, 32'h1);
            rd_reg(5'h10, v);
            chk("rand_start_status", v, 32'h1);
            check_cycle(0);
            run_from(1);
            finish_check((nc == 0) ? 1 : nc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cond_excitation_seq.md
Name: cond_excitation_seq

Overview:
- Memory-mapped controller that sequences the 2-bit conductivity-probe drive pins.
- Produces alternating-polarity excitation (forward / dead / reverse / dead) to prevent probe electrolysis.
- Issues a mid-phase ADC sample strobe tagged with polarity.
- Sits on the same CPU peripheral bus as the GPIO block and replaces direct CPU bit-banging of the probe pins.

Parameters:
- PH_W, 16, width of the phase-length register/counter
- DT_W, 8, width of the dead-time register/counter
- NC_W, 8, width of the cycle-count register/counter

Ports:
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-high
- addr  in  5  register byte offset
- cs  in  1  peripheral select
- rd  in  1  read strobe (reads are combinational; rd is not needed for decode)
- wr  in  1  write strobe, sampled at posedge when cs=1
- d_in  in  32  write data
- d_out  out  32  read data, combinational mux on addr
- mem_ready  out  1  constant 1; single-cycle access
- drive  out  2  probe pins: 00 off, 01 forward, 10 reverse; 11 is never driven
- sample_strb  out  1  one-cycle pulse at the middle of each drive phase
- sample_pol  out  1  polarity of the current phase: 0 forward, 1 reverse (valid with sample_strb)
- busy  out  1  sequence running

Behaviour:
- Registers (cs & wr at posedge):
  - 0x00 CTRL (write-only action bits; reads return {30'b0, cont, 0}):
    - bit0 START
    - bit1 CONT (stored)
    - bit2 ABORT
  - 0x04 PHASE_LEN[PH_W-1:0]; value 0 is treated as 1.
  - 0x08 DEAD_LEN[DT_W-1:0]; value 0 skips the dead states.
  - 0x0C NUM_CYC[NC_W-1:0]; value 0 is treated as 1.
  - 0x10 STATUS (read-only): {cyc_done[NC_W-1:0] at [15:8], done at [1], busy at [0]}. Any write clears done.
  - Other offsets read 0; writes to them are ignored.
- Reset values: drive=00, sample_strb=0, sample_pol=0, busy=0, done=0, cyc_done=0, PHASE_LEN=100, DEAD_LEN=10, NUM_CYC=1, CONT=0, FSM=IDLE.
- FSM states: IDLE, FWD, DEAD_A, REV, DEAD_B.
  - IDLE: START write at edge T enters FWD at T+1. The same edge clears done and cyc_done and sets busy.
  - FWD: drive=01 for exactly max(PHASE_LEN,1) cycles. Then DEAD_A if DEAD_LEN≠0, else REV.
  - DEAD_A: drive=00 for DEAD_LEN cycles, then REV.
  - REV: drive=10 for max(PHASE_LEN,1) cycles. Then DEAD_B, or directly the end-of-cycle check if DEAD_LEN=0.
  - End of cycle: cyc_done increments (saturating).
    - If CONT=0 and cyc_done+1 == max(NUM_CYC,1): go to IDLE, done=1, busy=0.
    - Otherwise go to FWD.
- Phase counter: reloads to 0 on each state entry. sample_strb=1 in the cycle where the counter equals (eff_len>>1) during FWD/REV only. sample_pol is 0 in FWD, 1 in REV, and holds its value elsewhere.
- Register changes while busy take effect at the next state entry. The current phase is never truncated or extended.
- START while busy is ignored (no restart).
- ABORT takes priority over START when written in the same write.
  - ABORT at edge T: IDLE at T+1, drive=00, busy=0, done unchanged, cyc_done retained.
- Reset mid-sequence returns everything to reset values at the next edge. drive is 00 from that edge.
- drive transitions go 01→00→10 only through a dead state when DEAD_LEN≠0. With DEAD_LEN=0, 01→10 is permitted directly.

Decomposition:
- Package cond_seq_pkg holds:
  - address offsets (CTRL, PHASE_LEN, DEAD_LEN, NUM_CYC, STATUS)
  - CTRL bit indices
  - FSM state encoding
  - drive encodings DRV_OFF/DRV_FWD/DRV_REV
  - reset defaults
- One sub-module, phase_timer: loadable up-counter with clear-on-entry, parameterised width, and outputs expire (cnt == len-1) and mid (cnt == len>>1).

Test Plan:
- Reset, then read all registers → PHASE_LEN=100, DEAD_LEN=10, NUM_CYC=1, STATUS=0, drive=00.
- PHASE_LEN=4, DEAD_LEN=2, NUM_CYC=2, START → drive sequence 01×4, 00×2, 10×4, 00×2, repeated twice. sample_strb pulses at counter 2 of each drive phase with pol 0,1,0,1. Then busy=0, done=1, cyc_done=2.
- DEAD_LEN=0, PHASE_LEN=1, NUM_CYC=3 → drive alternates 01,10 every cycle for 6 cycles. Strobe fires every cycle. done=1.
- CONT=1, START, run 5 cycles, write ABORT mid-REV → drive=00 next cycle, busy=0, done=0.
- START issued while busy with different PHASE_LEN → no restart. The new length applies from the next phase entry.
- Assert rst during FWD → next cycle drive=00, busy=0, and all registers at reset defaults.
